// File: rtl/rsa_pkg.sv
// Shared types and helpers for the modular exponentiation core.
//   state_e        : exponentiation FSM state encoding
//   modexp_latency : accept-to-done cycle count for a legal operand set
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SQR  = 3'd2,
    ST_MUL  = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  // ones = popcount(exponent); only used when const_time is 0.
  function automatic int unsigned modexp_latency(input int unsigned width,
                                                 input bit          const_time,
                                                 input int unsigned ones);
    if (const_time) return 2 * width * width + 2;
    return width * (width + ones) + 2;
  endfunction

endpackage

// File: rtl/modmul_serial.sv
// Serial interleaved (Blakley) modular multiplier: prod = a*b mod n.
// One bit of a per cycle, MSB first, exactly WIDTH cycles per multiply.
// The first step is taken in the start_i cycle using the live inputs, so the
// final product is available combinationally (prod_c_o, done_c_o) in the
// WIDTH-th cycle and a sequencer can chain multiplies with no idle cycles.
// Requires a < n and b < n.
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : begin a multiply (only while busy_o is low)
//   a_i, b_i, n_i  : operands and modulus, sampled with start_i
//   busy_o         : multiply in progress after the start cycle
//   done_c_o       : combinational, high in the final step cycle
//   prod_c_o       : combinational product, valid with done_c_o
//   acc_o          : live accumulator, low WIDTH bits
module modmul_serial #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             busy_o,
  output logic             done_c_o,
  output logic [WIDTH-1:0] prod_c_o,
  output logic [WIDTH-1:0] acc_o
);

  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned IW = $clog2(WIDTH);

  logic [AW-1:0]    acc_q;
  logic [WIDTH-1:0] a_q, b_q, n_q;
  logic [IW-1:0]    idx_q;
  logic             run_q;

  logic [WIDTH-1:0] cur_a, cur_b, cur_n;
  logic [AW-1:0]    cur_acc, step_c;
  logic [IW-1:0]    cur_idx;
  logic             active_c;

  // One Blakley step; 2*acc + b < 3n fits in WIDTH+2 bits.
  always_comb begin
    cur_a    = start_i ? a_i : a_q;
    cur_b    = start_i ? b_i : b_q;
    cur_n    = start_i ? n_i : n_q;
    cur_acc  = start_i ? '0 : acc_q;
    cur_idx  = start_i ? IW'(WIDTH - 1) : idx_q;
    active_c = start_i || run_q;
    step_c   = {cur_acc[AW-2:0], 1'b0} + (cur_a[cur_idx] ? AW'(cur_b) : '0);
    if (step_c >= AW'(cur_n)) step_c = step_c - AW'(cur_n);
    if (step_c >= AW'(cur_n)) step_c = step_c - AW'(cur_n);
    done_c_o = active_c && (cur_idx == '0);
    prod_c_o = step_c[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else if (active_c) begin
      acc_q <= step_c;
      idx_q <= cur_idx - IW'(1);
      run_q <= (cur_idx != '0);
      if (start_i) begin
        a_q <= a_i;
        b_q <= b_i;
        n_q <= n_i;
      end
    end
  end

  assign busy_o = run_q;
  assign acc_o  = acc_q[WIDTH-1:0];

endmodule

// File: rtl/modexp_core.sv
// Left-to-right binary modular exponentiation: result = base^exponent mod modulus.
// Sequences modmul_serial through one square and (optionally) one multiply per
// exponent bit, MSB first.
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : request, accepted only in IDLE
//   base, exponent, modulus  : operands, latched on the accept edge
//   busy                     : accept edge until done
//   done                     : one-cycle completion pulse
//   err                      : modulus==0 or base>=modulus, valid with done
//   result                   : held until the next completion
//   dbg                      : live multiplier accumulator
module modexp_core
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter bit          CONST_TIME = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] dbg
);

  localparam int unsigned IW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d;
  logic [WIDTH-1:0] r_q, r_d, result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             bad_q, bad_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic             bad_c, bit_c, last_bit_c, mul_start_c, mul_done_c, mul_busy;
  logic [WIDTH-1:0] mul_b_c, mul_prod_c, mul_acc;

  assign bad_c       = (mod_q == '0) || (base_q >= mod_q);
  assign bit_c       = exp_q[idx_q];
  assign last_bit_c  = (idx_q == '0);
  // A new multiply is launched in the first cycle of every SQR/MUL visit.
  assign mul_start_c = ((state_q == ST_SQR) || (state_q == ST_MUL)) && !mul_busy;
  assign mul_b_c     = (state_q == ST_MUL) ? base_q : r_q;

  modmul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start_c),
    .a_i      (r_q),
    .b_i      (mul_b_c),
    .n_i      (mod_q),
    .busy_o   (mul_busy),
    .done_c_o (mul_done_c),
    .prod_c_o (mul_prod_c),
    .acc_o    (mul_acc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = bad_c ? ST_FIN : ST_SQR;
      ST_SQR: begin
        if (mul_done_c) begin
          if (CONST_TIME || bit_c) state_d = ST_MUL;
          else if (last_bit_c)     state_d = ST_FIN;
          else                     state_d = ST_SQR;
        end
      end
      ST_MUL:  if (mul_done_c) state_d = last_bit_c ? ST_FIN : ST_SQR;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    r_d      = r_q;
    idx_d    = idx_q;
    bad_d    = bad_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d = base;
          exp_d  = exponent;
          mod_d  = modulus;
          busy_d = 1'b1;
          err_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        bad_d = bad_c;
        idx_d = IW'(WIDTH - 1);
        r_d   = (bad_c || (mod_q == WIDTH'(1))) ? '0 : WIDTH'(1);
      end
      ST_SQR: begin
        if (mul_done_c) begin
          r_d = mul_prod_c;
          // Skipped multiply: advance the bit here instead of in MUL.
          if (!(CONST_TIME || bit_c) && !last_bit_c) idx_d = idx_q - IW'(1);
        end
      end
      ST_MUL: begin
        if (mul_done_c) begin
          if (bit_c) r_d = mul_prod_c;
          if (!last_bit_c) idx_d = idx_q - IW'(1);
        end
      end
      ST_FIN: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        result_d = r_q;
        err_d    = bad_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      r_q      <= '0;
      idx_q    <= '0;
      bad_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      r_q      <= r_d;
      idx_q    <= idx_d;
      bad_q    <= bad_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign dbg    = mul_acc;

endmodule

// File: doc/modexp_core.md
MODEXP_CORE -- requirements
Module: modexp_core

Interface
REQ-001 Parameter WIDTH, default 64: operand width in bits; legal range 4..1024.
REQ-002 Parameter CONST_TIME, default 1: 1 = multiply step executed for every exponent bit; 0 = multiply step skipped for zero bits.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 base  input  WIDTH  message / ciphertext operand.
REQ-007 exponent  input  WIDTH  public or private exponent.
REQ-008 modulus  input  WIDTH  RSA modulus n.
REQ-009 busy  output  1  high from the start-accept edge until done.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 err  output  1  valid with done; flags illegal operands.
REQ-012 result  output  WIDTH  base^exponent mod modulus; held stable until the next accepted start.
REQ-013 dbg  output  WIDTH  live multiplier accumulator (low WIDTH bits), debug only.

Function
REQ-014 base, exponent and modulus SHALL be latched on the edge that accepts start; later input changes SHALL have no effect.
REQ-015 A start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-016 FSM states: IDLE, LOAD, SQR, MUL, FIN; IDLE->LOAD on start; LOAD->FIN on error, else LOAD->SQR; SQR->MUL or SQR->next SQR per REQ-019; after the LSB step ->FIN; FIN->IDLE unconditionally.
REQ-017 LOAD SHALL set the running result R=1 mod modulus and the bit index to WIDTH-1.
REQ-018 Exponentiation SHALL be left-to-right binary: per bit, SQR computes R=R*R mod n, then MUL computes R=R*base mod n when the bit is 1.
REQ-019 With CONST_TIME=1, MUL SHALL always run; when the bit is 0 its product SHALL be discarded. With CONST_TIME=0, MUL SHALL be skipped when the bit is 0.
REQ-020 Modular multiply SHALL be serial interleaved (Blakley), 1 multiplier bit per cycle, MSB first, exactly WIDTH cycles per multiply:
- acc = 2*acc + (a_i ? b : 0)
- then subtract n up to twice so that acc < n
REQ-021 The accumulator SHALL be WIDTH+2 bits wide; no intermediate overflow is permitted.
REQ-022 Latency, measured from the start-accept edge to the done=1 cycle, SHALL be 2*WIDTH*WIDTH+2 cycles when CONST_TIME=1.
REQ-023 When CONST_TIME=0, latency SHALL be WIDTH*(WIDTH+popcount(exponent))+2 cycles.
REQ-024 done, busy-fall and result update SHALL coincide in FIN; busy SHALL be 0 in the cycle after FIN.
REQ-025 Error condition: modulus==0, or base>=modulus. In that case the FSM SHALL go LOAD->FIN, done SHALL assert 2 cycles after accept, and result SHALL be 0 with err=1.
REQ-026 Boundary: modulus==1 -> result 0, err 0; exponent==0 -> result 1 mod n; base==0 with exponent!=0 -> result 0.
REQ-027 err SHALL be cleared on the next accepted start.

Reset
REQ-028 rst=1 at any edge SHALL force IDLE, including mid-operation; the operation in flight SHALL be abandoned with no done pulse.
REQ-029 Reset values: busy=0, done=0, err=0, result=0, dbg=0; all latched operands and the accumulator SHALL be zeroed.
REQ-030 A start sampled in the same cycle as rst=1 SHALL be ignored.

Structure
REQ-031 Package rsa_pkg SHALL hold the FSM state enum and the latency function (WIDTH, CONST_TIME).
REQ-032 The serial multiplier SHALL be a sub-module modmul_serial, parameterised by WIDTH, with a start/done handshake; modexp_core SHALL sequence it.

Verification (bench at WIDTH=16 unless stated)
REQ-033 Encrypt: base=65, exponent=17, modulus=3233, CONST_TIME=1 -> result=2790, err=0, done exactly 514 cycles after accept.
REQ-034 Decrypt: base=2790, exponent=2753, modulus=3233 -> result=65.
REQ-035 CONST_TIME=0: base=4, exponent=13, modulus=497 -> result=445, latency=16*(16+3)+2=306 cycles.
REQ-036 Errors and boundaries:
- modulus=0 -> err=1, result=0 after 2 cycles
- base=500, modulus=497 -> err=1
- exponent=0 -> result=1
- modulus=1 -> result=0
REQ-037 start re-pulsed at cycle 100 of a busy operation -> ignored, original result produced; rst pulsed at cycle 200 -> busy=0 next cycle, no done.
REQ-038 WIDTH=64: base=2, exponent=64, modulus=2^64-59 -> result=59; check against a reference model.
